keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- 4x4 matrix keypad scanner: the input-side counterpart of the board's display driver.
- Drives keypad rows one at a time and samples the columns.
- Debounces presses and releases.
- Delivers 4-bit key codes to the CPU-side consumer through a valid/ack handshake.
- Sits between the board keypad pins and the CPU I/O input register.

Parameters:
SCAN_DIV, 32'd50000, clock cycles each row is driven per sample period (minimum 4).
DEBOUNCE, 4'd4, consecutive identical samples needed to accept a press or a release (1..15).

Ports:
clkIn  input  1  system clock
rst  input  1  reset; asynchronous, active-high
col  input  4  keypad column lines, active-low, asynchronous to clkIn
row  output  4  keypad row drive; one-hot active-low
key  output  4  accepted key code = row_index*4 + col_index
keyValid  output  1  key holds an unconsumed code
keyAck  input  1  consumer takes key; honoured only while keyValid=1
keyHeld  output  1  debounced key currently down
overrun  output  1  sticky: a press was accepted while keyValid=1

Behaviour:
- Reset values (async, active-high): row=4'b1110, key=0, keyValid=0, keyHeld=0, overrun=0, state=SCAN, dwell counter=0, debounce counter=0, synchroniser flops=4'b1111.
- col passes through a 2-flop synchroniser before any use.
- Dwell counter counts 0..SCAN_DIV-1 and then wraps.
- A sample is taken only when the counter equals SCAN_DIV-1. This gives the row drive and synchroniser at least 2 cycles to settle.
- Sample decode: any column low = hit; col_index = lowest-numbered low column; row_index = currently driven row.
- SCAN state:
  - At each sample with no hit, row rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - On a hit: capture code, debounce count=1, go to PRESS. Row stays frozen.
- PRESS state (row frozen):
  - Sample with the same code: count+1. When count reaches DEBOUNCE, go to HELD.
  - Sample with a different code or no hit: go to SCAN and rotate to the next row.
  - With DEBOUNCE=1, the state goes straight to HELD on the first hit.
- Entry to HELD (single cycle event):
  - keyHeld<=1.
  - If keyValid=0, or keyAck=1 in that same cycle: key<=code and keyValid<=1. No overrun.
  - Otherwise: key is unchanged, overrun<=1.
- HELD state (row frozen):
  - Sample with no hit: release count+1. Sample with a hit: release count=0.
  - Presses of other columns in the frozen row are ignored.
  - When release count reaches DEBOUNCE: keyHeld<=0, go to SCAN, rotate to the next row.
- Handshake:
  - keyAck while keyValid=1 clears keyValid on the next edge, unless a new press is loaded that same edge.
  - keyAck while keyValid=0 has no effect.
  - overrun clears on the edge where keyAck=1 and keyValid=1.
- key is updated only on a load. It holds its value after keyValid clears.
- Reset mid-operation (PRESS or HELD) returns to SCAN with all reset values. No code is emitted.
- Per sample, the row drives for SCAN_DIV cycles. Press latency from the first sample is (DEBOUNCE-1)*SCAN_DIV cycles + 1 cycle to keyValid.

Test Plan (SCAN_DIV=8, DEBOUNCE=3):
- Reset: assert rst mid-dwell -> immediately row=1110, keyValid=0, keyHeld=0, overrun=0. Release rst -> row advances every 8 cycles: 1101, 1011, 0111, 1110.
- Clean press: col=4'b1011 whenever row=1101 -> held 3 samples, then keyValid=1, key=4'd6 (row1, col2), keyHeld=1. keyAck for 1 cycle -> keyValid=0, key stays 6. Release for 3 samples -> keyHeld=0, row moves to 1011.
- Bounce: col low for 1 sample, then high -> no keyValid, state back to SCAN, row advances. Press 2 of 3 samples, then drop -> no keyValid.
- Multiple columns: col=4'b0101 on row 0111 -> key=4'd13 (lowest column wins). While held, an additional column press produces no new code.
- Overrun: accept key 0, no ack, release, then accept key 15 -> key stays 0, overrun=1. keyAck -> keyValid=0, overrun=0. Ack on the same edge as a new load -> key=new code, keyValid stays 1, overrun=0.
- Reset during HELD: keyHeld=1, then pulse rst -> keyHeld=0, keyValid=0, row=1110. Key still down after reset -> re-detected and re-debounced, then a fresh keyValid.

Source files
------------

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad pin bundle plus the CPU-side key/valid/ack handshake
interface keypad_scan_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       keyValid;
  logic       keyAck;
  logic       keyHeld;
  logic       overrun;
  modport master (input col, keyAck, output row, key, keyValid, keyHeld, overrun);
  modport slave  (output col, keyAck, input row, key, keyValid, keyHeld, overrun);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and valid/ack key delivery
module keypad_scan #(
  parameter logic [31:0] SCAN_DIV = 32'd50000,
  parameter logic [3:0]  DEBOUNCE = 4'd4
) (
  input logic          clkIn,
  input logic          rst,
  keypad_scan_if.master bus
);
  typedef enum logic [1:0] {SCAN, PRESS, HELD} state_t;
  state_t      r_state, w_state_n;
  logic [31:0] r_cnt;
  logic [3:0]  r_sync1, r_sync2, r_row, r_key, r_code, r_db;
  logic        r_valid, r_held, r_ovr;
  logic [3:0]  w_row_n, w_key_n, w_code_n, w_db_n, w_code, w_rot;
  logic        w_valid_n, w_held_n, w_ovr_n, w_sample, w_hit, w_enter, w_ack;
  logic [1:0]  w_row_idx, w_col_idx;

  assign w_sample  = r_cnt == SCAN_DIV - 32'd1;
  assign w_hit     = r_sync2 != 4'hF;
  assign w_col_idx = !r_sync2[0] ? 2'd0 : !r_sync2[1] ? 2'd1 : !r_sync2[2] ? 2'd2 : 2'd3;
  assign w_row_idx = !r_row[0] ? 2'd0 : !r_row[1] ? 2'd1 : !r_row[2] ? 2'd2 : 2'd3;
  assign w_code    = {w_row_idx, w_col_idx};
  assign w_rot     = {r_row[2:0], r_row[3]};
  assign w_ack     = bus.keyAck && r_valid;

  // all registered state: column synchroniser, dwell counter, scan FSM and handshake
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_cnt   <= '0;
      r_state <= SCAN;
      r_row   <= 4'b1110;
      r_code  <= '0;
      r_db    <= '0;
      r_key   <= '0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync1 <= bus.col;
      r_sync2 <= r_sync1;
      r_cnt   <= w_sample ? '0 : r_cnt + 32'd1;
      r_state <= w_state_n;
      r_row   <= w_row_n;
      r_code  <= w_code_n;
      r_db    <= w_db_n;
      r_key   <= w_key_n;
      r_valid <= w_valid_n;
      r_held  <= w_held_n;
      r_ovr   <= w_ovr_n;
    end
  end

  // scan/debounce decisions happen only on sample ticks; handshake reacts every cycle
  always_comb begin
    w_state_n = r_state;
    w_row_n   = r_row;
    w_code_n  = r_code;
    w_db_n    = r_db;
    w_held_n  = r_held;
    w_enter   = 1'b0;
    if (w_sample)
      case (r_state)
        SCAN:
          if (w_hit) begin
            w_code_n  = w_code;
            w_db_n    = 4'd1;
            w_state_n = PRESS;
            if (DEBOUNCE == 4'd1) begin
              w_state_n = HELD;
              w_db_n    = 4'd0;
              w_enter   = 1'b1;
            end
          end else
            w_row_n = w_rot;
        PRESS:
          if (w_hit && w_code == r_code) begin
            w_db_n = r_db + 4'd1;
            if (r_db + 4'd1 == DEBOUNCE) begin
              w_state_n = HELD;
              w_db_n    = 4'd0;
              w_enter   = 1'b1;
            end
          end else begin
            w_state_n = SCAN;
            w_row_n   = w_rot;
          end
        HELD: begin
          w_db_n = w_hit ? 4'd0 : r_db + 4'd1;
          if (!w_hit && r_db + 4'd1 == DEBOUNCE) begin
            w_state_n = SCAN;
            w_row_n   = w_rot;
            w_held_n  = 1'b0;
          end
        end
        default: w_state_n = SCAN;
      endcase
    if (w_enter) w_held_n = 1'b1;
    w_key_n   = (w_enter && (!r_valid || bus.keyAck)) ? w_code_n : r_key;
    w_valid_n = (w_enter && (!r_valid || bus.keyAck)) ? 1'b1 : w_ack ? 1'b0 : r_valid;
    w_ovr_n   = (w_enter && r_valid && !bus.keyAck) ? 1'b1 : w_ack ? 1'b0 : r_ovr;
  end

  assign bus.row      = r_row;
  assign bus.key      = r_key;
  assign bus.keyValid = r_valid;
  assign bus.keyHeld  = r_held;
  assign bus.overrun  = r_ovr;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed checks of scanning, debounce, handshake and overrun
module tb_keypad_scan;
  logic       clkIn = 1'b0;
  logic       rst = 1'b1;
  logic       kp_en = 1'b0;
  logic [1:0] kp_r = 2'd0;
  logic [3:0] kp_c = 4'hF;
  logic [2:0] ph;
  int         checks = 0;
  int         errors = 0;

  keypad_scan_if bus();

  keypad_scan #(.SCAN_DIV(32'd8), .DEBOUNCE(4'd3)) dut (
    .clkIn(clkIn),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clkIn = ~clkIn;

  // a pressed key pulls its columns low only while its row is driven
  assign bus.col = (kp_en && !bus.row[kp_r]) ? kp_c : 4'hF;

  // bench timebase: phase 0 means a row sample edge just happened
  always @(posedge clkIn or posedge rst)
    if (rst) ph <= 3'd0;
    else ph <= ph + 3'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clkIn);
    #1;
  endtask

  task automatic next_sample();
    do step(1); while (ph != 3'd0);
  endtask

  task automatic samples(input int n);
    repeat (n) next_sample();
  endtask

  task automatic press(input logic [1:0] r, input logic [3:0] c);
    kp_r = r;
    kp_c = c;
    kp_en = 1'b1;
  endtask

  task automatic ack();
    bus.keyAck = 1'b1;
    step(1);
    bus.keyAck = 1'b0;
  endtask

  initial begin
    logic [3:0] rows [4];
    rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    bus.keyAck = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_row", 32'(bus.row), 32'h0E);
    chk("rst_key", 32'(bus.key), 32'h0);
    chk("rst_valid", 32'(bus.keyValid), 32'h0);
    chk("rst_held", 32'(bus.keyHeld), 32'h0);
    chk("rst_ovr", 32'(bus.overrun), 32'h0);
    next_sample();
    chk("first_rot", 32'(bus.row), 32'h0D);
    step(3);
    rst = 1'b1;
    #1;
    chk("midrst_row", 32'(bus.row), 32'h0E);
    chk("midrst_valid", 32'(bus.keyValid), 32'h0);
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_sample();
      chk($sformatf("rot%0d", i), 32'(bus.row), 32'(rows[i]));
    end
    press(2'd1, 4'b1011);
    samples(3);
    chk("press_latency", 32'(bus.keyValid), 32'h0);
    next_sample();
    chk("press_valid", 32'(bus.keyValid), 32'h1);
    chk("press_key", 32'(bus.key), 32'h6);
    chk("press_held", 32'(bus.keyHeld), 32'h1);
    ack();
    chk("ack_valid", 32'(bus.keyValid), 32'h0);
    chk("ack_key", 32'(bus.key), 32'h6);
    kp_en = 1'b0;
    samples(2);
    chk("rel_partial", 32'(bus.keyHeld), 32'h1);
    next_sample();
    chk("rel_held", 32'(bus.keyHeld), 32'h0);
    chk("rel_row", 32'(bus.row), 32'h0B);
    press(2'd3, 4'b1110);
    samples(2);
    chk("bounce_frozen", 32'(bus.row), 32'h07);
    kp_en = 1'b0;
    next_sample();
    chk("bounce_row", 32'(bus.row), 32'h0E);
    chk("bounce_valid", 32'(bus.keyValid), 32'h0);
    press(2'd0, 4'b1101);
    samples(2);
    chk("two_of_three_held", 32'(bus.keyHeld), 32'h0);
    kp_en = 1'b0;
    next_sample();
    chk("two_of_three_valid", 32'(bus.keyValid), 32'h0);
    chk("two_of_three_row", 32'(bus.row), 32'h0D);
    press(2'd3, 4'b0101);
    samples(5);
    chk("multi_valid", 32'(bus.keyValid), 32'h1);
    chk("multi_key", 32'(bus.key), 32'hD);
    ack();
    kp_c = 4'b0100;
    samples(3);
    chk("extra_valid", 32'(bus.keyValid), 32'h0);
    chk("extra_key", 32'(bus.key), 32'hD);
    chk("extra_held", 32'(bus.keyHeld), 32'h1);
    kp_en = 1'b0;
    samples(3);
    chk("multi_rel_row", 32'(bus.row), 32'h0E);
    press(2'd0, 4'b1110);
    samples(3);
    chk("k0_valid", 32'(bus.keyValid), 32'h1);
    chk("k0_key", 32'(bus.key), 32'h0);
    kp_en = 1'b0;
    samples(3);
    press(2'd3, 4'b0111);
    samples(5);
    chk("ovr_flag", 32'(bus.overrun), 32'h1);
    chk("ovr_key", 32'(bus.key), 32'h0);
    chk("ovr_valid", 32'(bus.keyValid), 32'h1);
    chk("ovr_held", 32'(bus.keyHeld), 32'h1);
    ack();
    chk("ovr_ack_valid", 32'(bus.keyValid), 32'h0);
    chk("ovr_ack_flag", 32'(bus.overrun), 32'h0);
    kp_en = 1'b0;
    samples(3);
    chk("ovr_rel_row", 32'(bus.row), 32'h0E);
    press(2'd0, 4'b1110);
    samples(3);
    chk("k0b_valid", 32'(bus.keyValid), 32'h1);
    kp_en = 1'b0;
    samples(3);
    chk("k0b_rel_row", 32'(bus.row), 32'h0D);
    press(2'd1, 4'b1101);
    samples(2);
    while (ph != 3'd7) step(1);
    ack();
    chk("ackload_key", 32'(bus.key), 32'h5);
    chk("ackload_valid", 32'(bus.keyValid), 32'h1);
    chk("ackload_ovr", 32'(bus.overrun), 32'h0);
    chk("ackload_held", 32'(bus.keyHeld), 32'h1);
    rst = 1'b1;
    #1;
    chk("heldrst_held", 32'(bus.keyHeld), 32'h0);
    chk("heldrst_valid", 32'(bus.keyValid), 32'h0);
    chk("heldrst_row", 32'(bus.row), 32'h0E);
    step(1);
    rst = 1'b0;
    samples(3);
    chk("redet_latency", 32'(bus.keyValid), 32'h0);
    next_sample();
    chk("redet_valid", 32'(bus.keyValid), 32'h1);
    chk("redet_key", 32'(bus.key), 32'h5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
